// File: rtl/st7735_spi_sink_if.sv
// ST7735 4-wire display link bundle (SCLK, MOSI, D/C, CS).
// Ports / modports:
//   master - the LCD driver side; drives all four link wires.
//   slave  - the receive-side decoder; samples all four link wires.
// Signals:
//   spi_clk  : link SCLK, asynchronous to any system clock
//   spi_mosi : serial data, MSB first
//   spi_dc   : 0 = command byte, 1 = data byte
//   spi_cs   : active-low chip select
interface st7735_spi_sink_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_dc;
    logic spi_cs;

    modport master (
        output spi_clk,
        output spi_mosi,
        output spi_dc,
        output spi_cs
    );

    modport slave (
        input spi_clk,
        input spi_mosi,
        input spi_dc,
        input spi_cs
    );
endinterface

// File: rtl/st7735_spi_sink.sv
// st7735_spi_sink - receive-side decoder for the ST7735 4-wire link.
// Oversamples the link in the clk domain, assembles MSB-first bytes, tracks
// the command context (CASET, RASET, RAMWR, SWRESET) and emits addressed
// RGB565 pixel writes for a framebuffer or scoreboard.
// Ports:
//   clk, reset     : system clock (>= 4x SCLK), synchronous active-high reset
//   link           : st7735_spi_sink_if.slave (SCLK, MOSI, D/C, CS)
//   cmd_valid      : 1-cycle pulse per completed command byte; cmd_byte held
//   param_valid    : 1-cycle pulse per data byte outside RAMWR; param_byte held
//   pix_valid      : 1-cycle pulse per completed pixel at (pix_x, pix_y)
//   pix_data       : RGB565, first byte in [15:8]
//   frame_done     : pulses with the pixel written at (xe, ye)
//   stray_data     : sticky flag, data byte seen while IDLE
module st7735_spi_sink #(
    parameter logic [7:0] DEF_XE = 8'd159,
    parameter logic [7:0] DEF_YE = 8'd79
) (
    input  logic                    clk,
    input  logic                    reset,
    st7735_spi_sink_if.slave        link,
    output logic                    cmd_valid,
    output logic [7:0]              cmd_byte,
    output logic                    param_valid,
    output logic [7:0]              param_byte,
    output logic                    pix_valid,
    output logic [7:0]              pix_x,
    output logic [7:0]              pix_y,
    output logic [15:0]             pix_data,
    output logic                    frame_done,
    output logic                    stray_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CASET = 3'd1,
        ST_RASET = 3'd2,
        ST_SKIP  = 3'd3,
        ST_RAMWR = 3'd4
    } state_t;

    // synchroniser and edge-detect state
    logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic       mosi_meta_r, mosi_sync_r;
    logic       dc_meta_r,   dc_sync_r;
    logic       cs_meta_r,   cs_sync_r;
    logic       rise_s;

    // byte assembly
    logic [2:0] bitcnt_r;
    logic [7:0] shift_r;
    logic       byte_done_r;
    logic       byte_dc_r;

    // command context
    state_t     state_r;
    logic [1:0] param_idx_r;
    logic [7:0] xs_r, xe_r, ys_r, ye_r;
    logic [7:0] col_r, row_r;
    logic       pix_phase_r;
    logic [7:0] pix_hi_r;

    assign rise_s = sclk_sync_r & ~sclk_prev_r;

    // Two-flop synchronisers for every link wire plus one cycle of SCLK history
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            dc_meta_r   <= 1'b0;
            dc_sync_r   <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
        end else begin
            sclk_meta_r <= link.spi_clk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            mosi_meta_r <= link.spi_mosi;
            mosi_sync_r <= mosi_meta_r;
            dc_meta_r   <= link.spi_dc;
            dc_sync_r   <= dc_meta_r;
            cs_meta_r   <= link.spi_cs;
            cs_sync_r   <= cs_meta_r;
        end
    end

    // Shift MOSI on SCLK rising edges while selected; flag each completed byte
    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt_r    <= 3'd0;
            shift_r     <= 8'd0;
            byte_done_r <= 1'b0;
            byte_dc_r   <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            if (cs_sync_r) begin
                // deselect throws away any partial byte; edges seen with CS high are ignored
                bitcnt_r <= 3'd0;
            end else if (rise_s) begin
                shift_r  <= {shift_r[6:0], mosi_sync_r};
                bitcnt_r <= bitcnt_r + 3'd1;   // wraps 7 -> 0 at byte end
                if (bitcnt_r == 3'd7) begin
                    byte_done_r <= 1'b1;
                    byte_dc_r   <= dc_sync_r;
                end else begin
                    byte_dc_r   <= byte_dc_r;
                end
            end else begin
                bitcnt_r <= bitcnt_r;
            end
        end
    end

    // Command FSM: decodes completed bytes into registered pulses and pixel writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            param_idx_r <= 2'd0;
            xs_r        <= 8'd0;
            xe_r        <= DEF_XE;
            ys_r        <= 8'd0;
            ye_r        <= DEF_YE;
            col_r       <= 8'd0;
            row_r       <= 8'd0;
            pix_phase_r <= 1'b0;
            pix_hi_r    <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'd0;
            param_valid <= 1'b0;
            param_byte  <= 8'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 8'd0;
            pix_y       <= 8'd0;
            pix_data    <= 16'd0;
            frame_done  <= 1'b0;
            stray_data  <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            param_valid <= 1'b0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            if (byte_done_r && !byte_dc_r) begin
                // a command byte aborts whatever was in progress
                cmd_valid   <= 1'b1;
                cmd_byte    <= shift_r;
                param_idx_r <= 2'd0;
                pix_phase_r <= 1'b0;
                case (shift_r)
                    8'h2A: state_r <= ST_CASET;
                    8'h2B: state_r <= ST_RASET;
                    8'h2C: begin
                        state_r <= ST_RAMWR;
                        col_r   <= xs_r;
                        row_r   <= ys_r;
                    end
                    8'h01: begin
                        state_r <= ST_IDLE;
                        xs_r    <= 8'd0;
                        xe_r    <= DEF_XE;
                        ys_r    <= 8'd0;
                        ye_r    <= DEF_YE;
                    end
                    default: state_r <= ST_SKIP;
                endcase
            end else if (byte_done_r) begin
                case (state_r)
                    ST_CASET, ST_RASET: begin
                        param_valid <= 1'b1;
                        param_byte  <= shift_r;
                        param_idx_r <= param_idx_r + 2'd1;
                        // only the low byte of each 16-bit start/end is kept
                        case (param_idx_r)
                            2'd1: begin
                                if (state_r == ST_CASET) xs_r <= shift_r;
                                else                     ys_r <= shift_r;
                            end
                            2'd3: begin
                                if (state_r == ST_CASET) xe_r <= shift_r;
                                else                     ye_r <= shift_r;
                                state_r <= ST_SKIP;
                            end
                            default: param_idx_r <= param_idx_r + 2'd1;
                        endcase
                    end
                    ST_SKIP: begin
                        param_valid <= 1'b1;
                        param_byte  <= shift_r;
                    end
                    ST_RAMWR: begin
                        if (!pix_phase_r) begin
                            pix_hi_r    <= shift_r;
                            pix_phase_r <= 1'b1;
                        end else begin
                            pix_phase_r <= 1'b0;
                            pix_valid   <= 1'b1;
                            pix_x       <= col_r;
                            pix_y       <= row_r;
                            pix_data    <= {pix_hi_r, shift_r};
                            frame_done  <= (col_r == xe_r) && (row_r == ye_r);
                            // 8-bit wrapping raster walk; xs > xe passes through 255 -> 0
                            if (col_r == xe_r) begin
                                col_r <= xs_r;
                                if (row_r == ye_r) row_r <= ys_r;
                                else               row_r <= row_r + 8'd1;
                            end else begin
                                col_r <= col_r + 8'd1;
                            end
                        end
                    end
                    ST_IDLE: stray_data <= 1'b1;
                    default: state_r <= ST_IDLE;
                endcase
            end else if (cs_sync_r) begin
                // deselect between bytes of a pixel drops the stored high byte
                pix_phase_r <= 1'b0;
            end else begin
                pix_phase_r <= pix_phase_r;
            end
        end
    end

endmodule
